hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the dual-slot (ALU + MEM) VLIW core.
- Sits beside the ID stage and its ID/EX register.
- Decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM registers advance, hold, or take a bubble.
- Handles three events: load-use hazards, taken branch/jump flushes, and data-memory wait states.

---
 rtl/hazard_stall_ctrl_pkg.sv | 23 ++
 rtl/hazard_stall_ctrl_if.sv | 58 +++++
 rtl/hazard_stall_ctrl_load_use_detect.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and widths for the hazard/stall sequencing controller.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 3;
  localparam int FLUSH_CNT_W    = 3;   // holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 7
  localparam int WAIT_CNT_W     = 8;   // wait counter saturates at 255
  localparam int PERF_CNT_W     = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  function automatic logic [WAIT_CNT_W-1:0] satIncWait(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + WAIT_CNT_W'(1);
  endfunction

  function automatic logic [PERF_CNT_W-1:0] satIncPerf(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/stall controller.
// The perf counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
  #(parameter int REG_AW = REG_AW_DEFAULT);

  logic              id_valid;
  logic [REG_AW-1:0] id_alu_rm;
  logic [REG_AW-1:0] id_alu_rn;
  logic              id_alu_uses_rn;
  logic [REG_AW-1:0] id_mem_rn;
  logic [REG_AW-1:0] id_mem_rd;
  logic              id_mem_isStore;
  logic              ex_valid;
  logic              ex_memRead;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_branchTaken;
  logic              ex_isJump;
  logic              dmem_req;
  logic              dmem_ready;

  logic pc_write;
  logic p1_pipeline_regWrite;
  logic p1_flush;
  logic p2_pipeline_regWrite;
  logic p2_bubble;
  logic p3_pipeline_regWrite;
  logic mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_load_stalls;
  logic [PERF_CNT_W-1:0] perf_flush_cycles;
  logic [PERF_CNT_W-1:0] perf_mem_wait_cycles;
`endif

  // Pipeline status flows in; there is no handshake, every signal is sampled each cycle.
  modport master (
    output id_valid, id_alu_rm, id_alu_rn, id_alu_uses_rn, id_mem_rn, id_mem_rd,
    output id_mem_isStore, ex_valid, ex_memRead, ex_mem_rd, ex_branchTaken, ex_isJump,
    output dmem_req, dmem_ready,
    input  pc_write, p1_pipeline_regWrite, p1_flush, p2_pipeline_regWrite, p2_bubble,
    input  p3_pipeline_regWrite, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input perf_load_stalls, perf_flush_cycles, perf_mem_wait_cycles
`endif
  );

  modport slave (
    input  id_valid, id_alu_rm, id_alu_rn, id_alu_uses_rn, id_mem_rn, id_mem_rd,
    input  id_mem_isStore, ex_valid, ex_memRead, ex_mem_rd, ex_branchTaken, ex_isJump,
    input  dmem_req, dmem_ready,
    output pc_write, p1_pipeline_regWrite, p1_flush, p2_pipeline_regWrite, p2_bubble,
    output p3_pipeline_regWrite, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output perf_load_stalls, perf_flush_cycles, perf_mem_wait_cycles
`endif
  );

endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the bundle sitting in ID.
module hazard_stall_ctrl_load_use_detect
  import hazard_stall_ctrl_pkg::*;
  #(parameter int REG_AW = REG_AW_DEFAULT)
(
  input  logic              idValid,
  input  logic [REG_AW-1:0] idAluRm,
  input  logic [REG_AW-1:0] idAluRn,
  input  logic              idAluUsesRn,
  input  logic [REG_AW-1:0] idMemRn,
  input  logic [REG_AW-1:0] idMemRd,
  input  logic              idMemIsStore,
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exMemRd,
  output logic              loadUse
);

  logic srcMatch;

  // Every register is real (no hardwired zero), so r0 matches like any other.
  assign srcMatch = (exMemRd == idAluRm)
                  | (idAluUsesRn  & (exMemRd == idAluRn))
                  | (exMemRd == idMemRn)
                  | (idMemIsStore & (exMemRd == idMemRd));

  assign loadUse = exValid & exMemRead & idValid & srcMatch;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: freeze on memory wait, flush on taken branch/jump,
// one-cycle bubble on load-use. HAZARD_PERF_CNT_EN adds saturating event counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
  #(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
  )
(
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_ctrl_if.slave   hz,
  output state_t               dbgState
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_LIM    = WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                 state, stateNext, savedState, savedStateNext, evalState;
  logic [FLUSH_CNT_W-1:0] flushCnt, flushCntNext;
  logic [WAIT_CNT_W-1:0]  waitCnt, waitCntNext;
  logic                   memTimeout, memTimeoutNext;
  logic                   memWait, branchReq, loadUse;
  logic                   pcWrite, p1En, p1Flush, p2En, p2Bubble, p3En;

  hazard_stall_ctrl_load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .idValid      (hz.id_valid),
    .idAluRm      (hz.id_alu_rm),
    .idAluRn      (hz.id_alu_rn),
    .idAluUsesRn  (hz.id_alu_uses_rn),
    .idMemRn      (hz.id_mem_rn),
    .idMemRd      (hz.id_mem_rd),
    .idMemIsStore (hz.id_mem_isStore),
    .exValid      (hz.ex_valid),
    .exMemRead    (hz.ex_memRead),
    .exMemRd      (hz.ex_mem_rd),
    .loadUse      (loadUse)
  );

  assign memWait   = hz.dmem_req & ~hz.dmem_ready;
  assign branchReq = hz.ex_valid & (hz.ex_branchTaken | hz.ex_isJump);

  // The release cycle of a wait behaves exactly like a cycle of the saved state,
  // so a branch held in EX or a pending flush cycle is serviced right then.
  assign evalState = (state == MEM_WAIT) ? savedState : state;

  always_comb begin
    stateNext      = state;
    savedStateNext = savedState;
    flushCntNext   = flushCnt;
    pcWrite        = 1'b1;
    p1En           = 1'b1;
    p1Flush        = 1'b0;
    p2En           = 1'b1;
    p2Bubble       = 1'b0;
    p3En           = 1'b1;

    if (memWait) begin
      pcWrite = 1'b0;
      p1En    = 1'b0;
      p2En    = 1'b0;
      p3En    = 1'b0;
      if (state != MEM_WAIT) begin
        savedStateNext = state;
        stateNext      = MEM_WAIT;
      end
    end else begin
      stateNext = evalState;
      case (evalState)
        FLUSH: begin
          p1Flush  = 1'b1;
          p2Bubble = 1'b1;
          if (flushCnt <= FLUSH_CNT_W'(1)) begin
            stateNext    = RUN;
            flushCntNext = '0;
          end else begin
            flushCntNext = flushCnt - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          if (branchReq) begin
            p1Flush  = 1'b1;
            p2Bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              stateNext    = FLUSH;
              flushCntNext = FLUSH_CNT_INIT;
            end
          end else if (loadUse) begin
            pcWrite  = 1'b0;
            p1En     = 1'b0;
            p2Bubble = 1'b1;
          end
        end
      endcase
    end
  end

  // Wait counter covers every frozen cycle, including the one that enters MEM_WAIT.
  assign waitCntNext    = memWait ? satIncWait(waitCnt) : '0;
  assign memTimeoutNext = memTimeout | (memWait & (waitCntNext >= TIMEOUT_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      savedState <= RUN;
      flushCnt   <= '0;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      state      <= stateNext;
      savedState <= savedStateNext;
      flushCnt   <= flushCntNext;
      waitCnt    <= waitCntNext;
      memTimeout <= memTimeoutNext;
    end
  end

  assign hz.pc_write             = pcWrite;
  assign hz.p1_pipeline_regWrite = p1En;
  assign hz.p1_flush             = p1Flush;
  assign hz.p2_pipeline_regWrite = p2En;
  assign hz.p2_bubble            = p2Bubble;
  assign hz.p3_pipeline_regWrite = p3En;
  assign hz.mem_timeout          = memTimeout;
  assign dbgState                = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perfLoad, perfFlush, perfWait;

  // A load-use stall is the only event that bubbles ID/EX without flushing IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfLoad  <= '0;
      perfFlush <= '0;
      perfWait  <= '0;
    end else begin
      if (p2Bubble & ~p1Flush) perfLoad  <= satIncPerf(perfLoad);
      if (p1Flush)             perfFlush <= satIncPerf(perfFlush);
      if (memWait)             perfWait  <= satIncPerf(perfWait);
    end
  end

  assign hz.perf_load_stalls     = perfLoad;
  assign hz.perf_flush_cycles    = perfFlush;
  assign hz.perf_mem_wait_cycles = perfWait;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (FLUSH_CYCLES = 3, MEM_TIMEOUT = 2).
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int REG_AW       = 3;
  localparam int FLUSH_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 2;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // {pc_write, p1_en, p1_flush, p2_en, p2_bubble, p3_en, mem_timeout}
  localparam logic [6:0] O_RUN    = 7'b1101010;
  localparam logic [6:0] O_STALL  = 7'b0001110;
  localparam logic [6:0] O_FLUSH  = 7'b1111110;
  localparam logic [6:0] O_FREEZE = 7'b0000000;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbgState;
  logic   toExp;
  int     checks = 0;
  int     failures = 0;
  int     expLoad = 0, expFlush = 0, expWait = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs;

  hazard_stall_ctrl_if #(.REG_AW(REG_AW)) hif ();

  hazard_stall_ctrl #(
    .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .hz(hif), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  assign obs = {dbgState, hif.pc_write, hif.p1_pipeline_regWrite, hif.p1_flush,
                hif.p2_pipeline_regWrite, hif.p2_bubble, hif.p3_pipeline_regWrite,
                hif.mem_timeout};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    hif.id_valid = 0; hif.id_alu_rm = '0; hif.id_alu_rn = '0; hif.id_alu_uses_rn = 0;
    hif.id_mem_rn = '0; hif.id_mem_rd = '0; hif.id_mem_isStore = 0;
    hif.ex_valid = 0; hif.ex_memRead = 0; hif.ex_mem_rd = '0;
    hif.ex_branchTaken = 0; hif.ex_isJump = 0; hif.dmem_req = 0; hif.dmem_ready = 0;
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_load(input int rd);
    hif.ex_valid = 1; hif.ex_memRead = 1; hif.ex_mem_rd = REG_AW'(rd);
  endtask

  task automatic set_id(input int rm, input int rn, input logic usesRn,
                        input int mrn, input int mrd, input logic isStore);
    hif.id_valid = 1; hif.id_alu_rm = REG_AW'(rm); hif.id_alu_rn = REG_AW'(rn);
    hif.id_alu_uses_rn = usesRn; hif.id_mem_rn = REG_AW'(mrn);
    hif.id_mem_rd = REG_AW'(mrd); hif.id_mem_isStore = isStore;
  endtask

  task automatic set_branch(input logic jump);
    hif.ex_valid = 1;
    if (jump) hif.ex_isJump = 1;
    else      hif.ex_branchTaken = 1;
  endtask

  task automatic set_mem(input logic ready);
    hif.dmem_req = 1; hif.dmem_ready = ready;
  endtask

  // Builds the expected vector and tallies the expected perf events.
  function automatic logic [8:0] expv(input logic [1:0] st, input logic [6:0] o);
    if (o == O_STALL)  expLoad++;
    if (o == O_FLUSH)  expFlush++;
    if (o == O_FREEZE) expWait++;
    return {st, o | {6'b0, toExp}};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] exp;
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    exp_q.push_back({S_RUN, O_RUN});
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL reset_state got=%b expected=%b", obs, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({hif.perf_load_stalls, hif.perf_flush_cycles, hif.perf_mem_wait_cycles} !== 48'd0) begin
      failures++; $display("FAIL reset_perf got=%h/%h/%h expected=0", hif.perf_load_stalls,
                           hif.perf_flush_cycles, hif.perf_mem_wait_cycles);
    end
`endif
    expLoad = 0; expFlush = 0; expWait = 0;
    reset = 0;
  endtask

  task automatic test_load_use();
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) begin
      start_cycle();
      case (i)
        0: begin set_load(3); set_id(3, 1, 0, 2, 4, 0); exp_q.push_back(expv(S_RUN, O_STALL)); end
        1: begin set_id(3, 1, 0, 2, 4, 0); exp_q.push_back(expv(S_RUN, O_RUN)); end
        default: exp_q.push_back(expv(S_RUN, O_RUN));
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL load_use[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_no_false_hazard();
    logic [8:0] exp;
    for (int i = 0; i < 8; i++) begin
      start_cycle();
      case (i)
        0: begin set_load(5); set_id(1, 5, 0, 2, 6, 0); exp_q.push_back(expv(S_RUN, O_RUN)); end
        1: begin set_load(5); set_id(1, 2, 0, 3, 5, 1); exp_q.push_back(expv(S_RUN, O_STALL)); end
        2: begin set_id(1, 2, 0, 3, 5, 1); exp_q.push_back(expv(S_RUN, O_RUN)); end
        3: begin set_load(5); set_id(1, 5, 1, 2, 6, 0); exp_q.push_back(expv(S_RUN, O_STALL)); end
        4: begin set_load(5); set_id(1, 2, 0, 5, 6, 0); exp_q.push_back(expv(S_RUN, O_STALL)); end
        5: begin set_load(5); set_id(1, 2, 1, 3, 5, 0); exp_q.push_back(expv(S_RUN, O_RUN)); end
        6: begin set_load(5); set_id(5, 2, 0, 3, 6, 0); hif.id_valid = 0;
                 exp_q.push_back(expv(S_RUN, O_RUN)); end
        default: begin set_load(5); set_id(5, 2, 0, 3, 6, 0); hif.ex_memRead = 0;
                       exp_q.push_back(expv(S_RUN, O_RUN)); end
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL no_false_hazard[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_random_load_use();
    logic [8:0] exp;
    int rd, rm, rn, mrn, mrd;
    logic usesRn, isStore, haz;
    for (int i = 0; i < 40; i++) begin
      start_cycle();
      if (i % 2 == 0) begin
        rd = $urandom_range(7, 0); rm = $urandom_range(7, 0); rn = $urandom_range(7, 0);
        mrn = $urandom_range(7, 0); mrd = $urandom_range(7, 0);
        usesRn = 1'($urandom_range(1, 0)); isStore = 1'($urandom_range(1, 0));
        haz = (rd == rm) || (usesRn && rd == rn) || (rd == mrn) || (isStore && rd == mrd);
        set_load(rd); set_id(rm, rn, usesRn, mrn, mrd, isStore);
        exp_q.push_back(expv(S_RUN, haz ? O_STALL : O_RUN));
      end else begin
        set_id(rm, rn, usesRn, mrn, mrd, isStore);
        exp_q.push_back(expv(S_RUN, O_RUN));
      end
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL random_load_use[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_branch_flush();
    logic [8:0] exp;
    for (int i = 0; i < 9; i++) begin
      start_cycle();
      case (i)
        0: begin set_branch(0); exp_q.push_back(expv(S_RUN, O_FLUSH)); end
        1: begin set_branch(0); exp_q.push_back(expv(S_FLUSH, O_FLUSH)); end
        2: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        3: exp_q.push_back(expv(S_RUN, O_RUN));
        4: begin set_branch(1); exp_q.push_back(expv(S_RUN, O_FLUSH)); end
        5: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        6: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        7: exp_q.push_back(expv(S_RUN, O_RUN));
        default: begin set_branch(0); hif.ex_valid = 0; exp_q.push_back(expv(S_RUN, O_RUN)); end
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL branch_flush[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp;
    for (int i = 0; i < 10; i++) begin
      start_cycle();
      case (i)
        0: begin set_branch(0); set_load(2); hif.ex_branchTaken = 1; set_id(2, 0, 0, 1, 1, 0);
                 exp_q.push_back(expv(S_RUN, O_FLUSH)); end
        1: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        2: begin set_mem(0); exp_q.push_back(expv(S_FLUSH, O_FREEZE)); end
        3: begin set_mem(1); exp_q.push_back(expv(S_WAIT, O_FLUSH)); end
        4: exp_q.push_back(expv(S_RUN, O_RUN));
        5: begin set_mem(0); set_branch(1); exp_q.push_back(expv(S_RUN, O_FREEZE)); end
        6: begin set_mem(1); set_branch(1); exp_q.push_back(expv(S_WAIT, O_FLUSH)); end
        7: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        8: exp_q.push_back(expv(S_FLUSH, O_FLUSH));
        default: exp_q.push_back(expv(S_RUN, O_RUN));
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL simultaneous[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] exp;
    for (int i = 0; i < 7; i++) begin
      start_cycle();
      case (i)
        0: begin set_mem(0); exp_q.push_back(expv(S_RUN, O_FREEZE)); end
        1: begin set_mem(0); exp_q.push_back(expv(S_WAIT, O_FREEZE)); end
        2: begin set_mem(0); toExp = 1; exp_q.push_back(expv(S_WAIT, O_FREEZE)); end
        3: begin set_mem(0); exp_q.push_back(expv(S_WAIT, O_FREEZE)); end
        4: begin set_mem(1); exp_q.push_back(expv(S_WAIT, O_RUN)); end
        5: exp_q.push_back(expv(S_RUN, O_RUN));
        default: begin set_load(4); set_id(0, 4, 1, 1, 2, 0); exp_q.push_back(expv(S_RUN, O_STALL)); end
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL mem_wait[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) begin
      start_cycle();
      case (i)
        0: begin set_mem(0); exp_q.push_back(expv(S_RUN, O_FREEZE)); end
        1: begin set_mem(0); reset = 1; exp_q.push_back(expv(S_WAIT, O_FREEZE)); end
        default: begin
          reset = 0; toExp = 0; expLoad = 0; expFlush = 0; expWait = 0;
          exp_q.push_back(expv(S_RUN, O_RUN));
        end
      endcase
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL reset_mid[%0d] got=%b expected=%b", i, obs, exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      // Counters are registered: at this sample they reflect all earlier cycles only.
      if (i == 1) begin
        checks++;
        if (hif.perf_load_stalls !== 16'(expLoad) || hif.perf_flush_cycles !== 16'(expFlush) ||
            hif.perf_mem_wait_cycles !== 16'(expWait - 1)) begin
          failures++; $display("FAIL perf_before_reset got=%0d/%0d/%0d expected=%0d/%0d/%0d",
                               hif.perf_load_stalls, hif.perf_flush_cycles, hif.perf_mem_wait_cycles,
                               expLoad, expFlush, expWait - 1);
        end
      end
      if (i == 2) begin
        checks++;
        if ({hif.perf_load_stalls, hif.perf_flush_cycles, hif.perf_mem_wait_cycles} !== 48'd0) begin
          failures++; $display("FAIL perf_after_reset got=%0d/%0d/%0d expected=0/0/0",
                               hif.perf_load_stalls, hif.perf_flush_cycles, hif.perf_mem_wait_cycles);
        end
      end
`endif
    end
  endtask

  initial begin
    toExp = 0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_random_load_use();
    test_branch_flush();
    test_simultaneous();
    test_mem_wait();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
